// File: rtl/lin_class_frame_stats.sv
// ---------------------------------------------------------------------------
// lin_class_frame_stats
//
// Sits directly downstream of the linear classifier. The frame sideband
// {valid, sof, eof} is delayed by LATENCY cycles so it lines up with the
// classifier's wgt_sum/pos outputs. The aligned samples then feed per-frame
// statistics: sample count, positive count, signed max, min and sum.
// At end of frame one result record is published through a one-entry
// valid/ready output buffer.
//
// Handshake: o_res_valid/i_res_ready. A record transfers on a rising edge
// where both are high. While o_res_valid=1 and i_res_ready=0 every record
// output holds steady. A record that finishes while the buffer is full and
// is not draining in that same cycle is dropped, and o_overflow is set.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_in_valid/sof/eof     sideband presented with the classifier inputs
//   i_wgt_sum, i_pos       classifier outputs (LATENCY cycles later)
//   i_res_ready            consumer accepts the result record
//   o_res_valid            result record available
//   o_smp_cnt, o_pos_cnt   saturating sample / positive counts
//   o_wgt_max, o_wgt_min   signed extremes of wgt_sum over the frame
//   o_wgt_acc              signed wrap-around sum of wgt_sum over the frame
//   o_busy                 FSM is inside a frame (ACCUM)
//   o_overflow             sticky: a finished record was dropped
//   o_frame_err            sticky: sof arrived inside an open frame
// ---------------------------------------------------------------------------
module lin_class_frame_stats #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 12,
    parameter int ACC_W   = 28
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic             i_sof,
    input  logic             i_eof,
    input  logic [15:0]      i_wgt_sum,
    input  logic             i_pos,
    input  logic             i_res_ready,
    output logic             o_res_valid,
    output logic [CNT_W-1:0] o_smp_cnt,
    output logic [CNT_W-1:0] o_pos_cnt,
    output logic [15:0]      o_wgt_max,
    output logic [15:0]      o_wgt_min,
    output logic [ACC_W-1:0] o_wgt_acc,
    output logic             o_busy,
    output logic             o_overflow,
    output logic             o_frame_err
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t state;

    // Sideband delay line, element [LATENCY-1] is the aligned sample.
    logic [2:0] dly [LATENCY];
    logic       a_v, a_sof, a_eof;

    assign {a_v, a_sof, a_eof} = dly[LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LATENCY; k++) dly[k] <= '0;
        end else begin
            dly[0] <= {i_in_valid, i_sof, i_eof};
            for (int k = 1; k < LATENCY; k++) dly[k] <= dly[k-1];
        end
    end

    // Working registers of the open frame and their next values.
    logic [CNT_W-1:0] w_smp, w_pos, n_smp, n_pos;
    logic [15:0]      w_max, w_min, n_max, n_min;
    logic [ACC_W-1:0] w_acc, n_acc, wgt_ext;
    logic             take, fin;

    always_comb begin
        wgt_ext = {{(ACC_W-16){i_wgt_sum[15]}}, i_wgt_sum};
        // In IDLE only a sof sample opens a frame; in ACCUM every valid
        // sample counts (a sof there restarts the frame from this sample).
        take = a_v && (state == ACCUM || a_sof);
        fin  = take && a_eof;
        if (a_sof) begin
            n_smp = CNT_W'(1);
            n_pos = CNT_W'(i_pos);
            n_max = i_wgt_sum;
            n_min = i_wgt_sum;
            n_acc = wgt_ext;
        end else begin
            n_smp = (&w_smp) ? w_smp : w_smp + CNT_W'(1);
            n_pos = (i_pos && !(&w_pos)) ? w_pos + CNT_W'(1) : w_pos;
            n_max = ($signed(i_wgt_sum) > $signed(w_max)) ? i_wgt_sum : w_max;
            n_min = ($signed(i_wgt_sum) < $signed(w_min)) ? i_wgt_sum : w_min;
            n_acc = w_acc + wgt_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            w_smp       <= '0;
            w_pos       <= '0;
            w_max       <= '0;
            w_min       <= '0;
            w_acc       <= '0;
            o_res_valid <= 1'b0;
            o_smp_cnt   <= '0;
            o_pos_cnt   <= '0;
            o_wgt_max   <= '0;
            o_wgt_min   <= '0;
            o_wgt_acc   <= '0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (take) begin
                w_smp <= n_smp;
                w_pos <= n_pos;
                w_max <= n_max;
                w_min <= n_min;
                w_acc <= n_acc;
                state <= fin ? IDLE : ACCUM;
                if (state == ACCUM && a_sof) o_frame_err <= 1'b1;
            end
            // The buffer accepts a new record when empty or draining now.
            if (fin && (!o_res_valid || i_res_ready)) begin
                o_res_valid <= 1'b1;
                o_smp_cnt   <= n_smp;
                o_pos_cnt   <= n_pos;
                o_wgt_max   <= n_max;
                o_wgt_min   <= n_min;
                o_wgt_acc   <= n_acc;
            end else begin
                if (fin) o_overflow <= 1'b1;
                if (o_res_valid && i_res_ready) o_res_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state == ACCUM);

endmodule
